// File: rtl/mem_req_resp.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : mem_req_resp
// Description : Word-addressed memory behind a valid/ready request port and a
//               valid/ready response port.
//               - Reads capture the addressed word when the request is
//                 accepted and place it in a 2-entry in-order response queue.
//               - Writes update storage when the request is accepted.
//               Optional feature macro: ECE2300_MEM_WRITE_ACK_EN.
//               - Defined: every accepted write also queues an acknowledge
//                 (resp_type=1, resp_data=0).
//               - Undefined: writes produce no response and are not held off
//                 by a full queue.
// Ports       : clk        - clock, rising edge active
//               reset      - asynchronous, active-low reset
//               req_val    - request valid
//               req_rdy    - request ready
//               req_type   - 0 = read, 1 = write
//               req_addr   - word address, $clog2(NWORDS) bits
//               req_wdata  - write data, DATA_BITS bits
//               resp_val   - response valid (queue not empty)
//               resp_rdy   - response ready
//               resp_type  - type of the request answered by the head entry
//               resp_data  - read data of the head entry (0 for write acks)
// Parameters  : NWORDS (power of two, 4..256), DATA_BITS
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module mem_req_resp #(
   parameter int NWORDS    = 16,
   parameter int DATA_BITS = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req_val,
   output logic                      req_rdy,
   input  logic                      req_type,
   input  logic [$clog2(NWORDS)-1:0] req_addr,
   input  logic [DATA_BITS-1:0]      req_wdata,
   output logic                      resp_val,
   input  logic                      resp_rdy,
   output logic                      resp_type,
   output logic [DATA_BITS-1:0]      resp_data
);

   // Storage is deliberately not reset: a reset only discards queued responses.
   logic [DATA_BITS-1:0] mem [NWORDS];

   // Two-entry response queue.
   logic                 q_type [2];
   logic [DATA_BITS-1:0] q_data [2];
   logic                 wr_ptr;
   logic                 rd_ptr;
   logic [1:0]           count;

   logic                 room;
   logic                 deq;
   logic                 enq;
   logic                 wr_en;
   logic                 enq_type;
   logic [DATA_BITS-1:0] enq_data;

   always_comb begin
      deq      = (count != 2'd0) && resp_rdy;
      // A full queue only has room when its head leaves this same cycle;
      // count==2 already implies resp_val, so resp_rdy alone decides.
      room     = (count != 2'd2) || resp_rdy;
`ifdef ECE2300_MEM_WRITE_ACK_EN
      req_rdy  = reset && room;
      wr_en    = req_val && req_rdy && req_type;
      enq      = req_val && req_rdy;
      enq_type = req_type;
      enq_data = req_type ? '0 : mem[req_addr];
`else
      // Writes never occupy a queue slot, so only reads wait for room.
      req_rdy  = reset && (room || req_type);
      wr_en    = req_val && req_rdy && req_type;
      enq      = req_val && req_rdy && !req_type;
      enq_type = 1'b0;
      enq_data = mem[req_addr];
`endif
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[req_addr] <= req_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count     <= 2'd0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         q_type[0] <= 1'b0;
         q_type[1] <= 1'b0;
         q_data[0] <= '0;
         q_data[1] <= '0;
      end else begin
         if (enq) begin
            q_type[wr_ptr] <= enq_type;
            q_data[wr_ptr] <= enq_data;
            wr_ptr         <= ~wr_ptr;
         end
         if (deq) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({enq, deq})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Head outputs are forced to zero when the queue is empty.
   always_comb begin
      resp_val  = (count != 2'd0);
      resp_type = resp_val & q_type[rd_ptr];
      resp_data = resp_val ? q_data[rd_ptr] : '0;
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_req_resp.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_mem_req_resp
// Description : Self-checking bench for mem_req_resp (NWORDS=16, DATA_BITS=8).
//               A reference model (array + response queue) predicts req_rdy
//               and the head of the response queue every cycle. Honours
//               ECE2300_MEM_WRITE_ACK_EN when defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_mem_req_resp;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_val;
   logic       req_rdy;
   logic       req_type;
   logic [3:0] req_addr;
   logic [7:0] req_wdata;
   logic       resp_val;
   logic       resp_rdy;
   logic       resp_type;
   logic [7:0] resp_data;

   mem_req_resp #(.NWORDS(16), .DATA_BITS(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_val   (req_val),
      .req_rdy   (req_rdy),
      .req_type  (req_type),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .resp_val  (resp_val),
      .resp_rdy  (resp_rdy),
      .resp_type (resp_type),
      .resp_data (resp_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       t;
      logic [7:0] d;
   } ent_t;

   logic [7:0] ref_mem [16];
   ent_t       q [$];
   int         total = 0;
   int         bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: a slot is free if fewer than two responses are held, or if the
   // head is being taken this cycle. Writes without acks never need a slot.
   function automatic logic model_rdy(input logic t, input logic rr);
      logic free;
      if (!reset) return 1'b0;
      free = (q.size() < 2) || rr;
`ifdef ECE2300_MEM_WRITE_ACK_EN
      return free;
`else
      return free || t;
`endif
   endfunction

   // One clock cycle: drive after the falling edge, compare, then advance the
   // model at the rising edge.
   task automatic step(input logic v, input logic t, input logic [3:0] a,
                       input logic [7:0] d, input logic rr,
                       output logic got_rdy, output logic [7:0] got_data);
      logic er;
      @(negedge clk);
      req_val = v; req_type = t; req_addr = a; req_wdata = d; resp_rdy = rr;
      #1;
      er       = model_rdy(t, rr);
      got_rdy  = req_rdy;
      got_data = resp_data;
      chk("req_rdy", req_rdy, er);
      chk("resp_val", resp_val, q.size() != 0);
      if (q.size() != 0) begin
         chk("resp_type", resp_type, q[0].t);
         chk("resp_data", resp_data, q[0].d);
      end else begin
         chk("resp_type_idle", resp_type, 0);
         chk("resp_data_idle", resp_data, 0);
      end
      @(posedge clk);
      if (q.size() != 0 && rr) void'(q.pop_front());
      if (v && er) begin
         if (!t) begin
            q.push_back('{t: 1'b0, d: ref_mem[a]});
         end else begin
`ifdef ECE2300_MEM_WRITE_ACK_EN
            q.push_back('{t: 1'b1, d: 8'h00});
`endif
            ref_mem[a] = d;
         end
      end
   endtask

   // Reset pulse between clock edges; inputs idle so the following edge is quiet.
   task automatic reset_pulse();
      @(negedge clk);
      req_val  = 1'b0;
      resp_rdy = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("rst_resp_val", resp_val, 0);
      chk("rst_req_rdy", req_rdy, 0);
      chk("rst_resp_type", resp_type, 0);
      chk("rst_resp_data", resp_data, 0);
      q.delete();
      #1 reset = 1'b1;
   endtask

   task automatic drain();
      logic       gr;
      logic [7:0] gd;
      step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, gr, gd);
      step(1'b0, 1'b0, 4'd0, 8'd0, 1'b1, gr, gd);
   endtask

   initial begin
      logic       gr;
      logic [7:0] gd;
      logic [7:0] d0, d1, d2;

      reset = 1'b0; req_val = 1'b0; req_type = 1'b0; req_addr = '0;
      req_wdata = '0; resp_rdy = 1'b0;
      #2;
      chk("init_resp_val", resp_val, 0);
      chk("init_req_rdy", req_rdy, 0);
      chk("init_resp_type", resp_type, 0);
      chk("init_resp_data", resp_data, 0);
      @(negedge clk);
      reset = 1'b1;

      // Fill all of storage so every later read has a defined value.
      for (int i = 0; i < 16; i++)
         step(1'b1, 1'b1, 4'(i), 8'($urandom), 1'b1, gr, gd);
      drain();

      // Write 0xA5 to 3 then read it back.
      step(1'b1, 1'b1, 4'd3, 8'hA5, 1'b1, gr, gd);
      step(1'b1, 1'b0, 4'd3, 8'h00, 1'b1, gr, gd);
      #1 chk("wr_rd_a5", resp_data, 8'hA5);
      chk("wr_rd_a5_type", resp_type, 0);
      drain();

      // Three reads with the response side stalled; third must wait.
      step(1'b1, 1'b1, 4'd0, 8'h11, 1'b1, gr, gd);
      step(1'b1, 1'b1, 4'd1, 8'h22, 1'b1, gr, gd);
      step(1'b1, 1'b1, 4'd2, 8'h33, 1'b1, gr, gd);
      drain();
      step(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, gr, gd);
      step(1'b1, 1'b0, 4'd1, 8'h00, 1'b0, gr, gd);
      step(1'b1, 1'b0, 4'd2, 8'h00, 1'b0, gr, gd);
      chk("third_read_blocked", gr, 0);
      step(1'b1, 1'b0, 4'd2, 8'h00, 1'b1, gr, gd);
      chk("full_deq_rdy", gr, 1);
      d0 = gd;
      step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, gr, d1);
      step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, gr, d2);
      chk("drain_0", d0, 8'h11);
      chk("drain_1", d1, 8'h22);
      chk("drain_2", d2, 8'h33);

      // Enqueue and dequeue together while full.
      step(1'b1, 1'b0, 4'd4, 8'h00, 1'b0, gr, gd);
      step(1'b1, 1'b0, 4'd5, 8'h00, 1'b0, gr, gd);
      step(1'b1, 1'b0, 4'd6, 8'h00, 1'b1, gr, gd);
      chk("full_swap_rdy", gr, 1);
      step(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, gr, gd);
      chk("full_swap_val", resp_val, 1);
      drain();

      // Reset with two queued responses; storage survives.
      step(1'b1, 1'b1, 4'd5, 8'h3C, 1'b1, gr, gd);
      drain();
      step(1'b1, 1'b0, 4'd5, 8'h00, 1'b0, gr, gd);
      step(1'b1, 1'b0, 4'd6, 8'h00, 1'b0, gr, gd);
      reset_pulse();
      step(1'b1, 1'b0, 4'd5, 8'h00, 1'b1, gr, gd);
      chk("post_rst_rdy", gr, 1);
      step(1'b0, 1'b0, 4'd0, 8'h00, 1'b1, gr, gd);
      chk("post_rst_old_data", gd, 8'h3C);

      // Back-to-back reads across the address range.
      step(1'b1, 1'b0, 4'd15, 8'h00, 1'b1, gr, gd);
      step(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, gr, gd);
      step(1'b1, 1'b0, 4'd15, 8'h00, 1'b1, gr, gd);
      step(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, gr, gd);
      drain();

      // Four writes with the response side stalled.
      for (int i = 0; i < 4; i++)
         step(1'b1, 1'b1, 4'(8 + i), 8'(8'h50 + i), 1'b0, gr, gd);
      drain();

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 2000; n++) begin
         if (n % 400 == 399) reset_pulse();
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              4'($urandom), 8'($urandom), 1'($urandom_range(0, 2) != 0), gr, gd);
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_req_resp.md
MEM_REQ_RESP -- requirements
Module: mem_req_resp

Interface
REQ-001 Parameter NWORDS, default 16, number of memory words (power of two, 4..256).
REQ-002 Parameter DATA_BITS, default 8, width of each word.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (reset==0 clears state immediately, independent of clk).
REQ-005 req_val  input  1  request valid.
REQ-006 req_rdy  output  1  request ready; transfer when req_val && req_rdy at rising edge.
REQ-007 req_type  input  1  0 = read, 1 = write.
REQ-008 req_addr  input  $clog2(NWORDS)  word address.
REQ-009 req_wdata  input  DATA_BITS  write data; ignored on reads.
REQ-010 resp_val  output  1  response valid.
REQ-011 resp_rdy  input  1  response ready; transfer when resp_val && resp_rdy at rising edge.
REQ-012 resp_type  output  1  type of the request this response answers.
REQ-013 resp_data  output  DATA_BITS  read data; 0 for write responses.

Function
REQ-014 The block SHALL hold NWORDS x DATA_BITS storage and a 2-entry FIFO response queue.
REQ-015 req_rdy SHALL equal 1 iff queue occupancy after this cycle's dequeue is below 2 (occupancy<2, or occupancy==2 with resp_val&&resp_rdy this cycle).
REQ-016 An accepted write SHALL update storage at that edge; an accepted read SHALL capture storage[req_addr] at that edge into the queue.
REQ-017 Minimum latency SHALL be 1 cycle: a request accepted at edge N yields resp_val=1 after edge N when the queue was empty.
REQ-018 Responses SHALL leave in request order; resp_val=1 iff occupancy>0; outputs show the head entry.
REQ-019 A read following a write to the same address in a later cycle SHALL return the written value; read data is captured at acceptance, not at dequeue.
REQ-020 Simultaneous enqueue and dequeue at occupancy 1 or 2 SHALL leave occupancy unchanged and preserve order.
REQ-021 Read/write pointers SHALL be 1 bit each and wrap 1->0; occupancy SHALL be 2 bits (0..2), never exceeding 2.
REQ-022 Queue state SHALL depend only on registered state and inputs; no combinational path from resp_rdy to resp_val, only resp_rdy to req_rdy.
REQ-023 Head outputs SHALL hold stable while resp_val=1 and resp_rdy=0.

Reset
REQ-024 While reset==0: occupancy=0, pointers=0, resp_val=0, req_rdy=0, resp_type=0, resp_data=0.
REQ-025 Reset assertion mid-transaction SHALL discard queued responses; storage contents SHALL NOT be cleared.
REQ-026 req_rdy SHALL become 1 in the first cycle after reset deasserts.

Configuration
REQ-027 Macro ECE2300_MEM_WRITE_ACK_EN: when defined, every accepted write SHALL enqueue a response with resp_type=1, resp_data=0.
REQ-028 Without ECE2300_MEM_WRITE_ACK_EN, writes SHALL NOT enqueue responses and SHALL be accepted whenever reset==1 (req_rdy gating applies to reads only).

Verification
REQ-029 Write 0xA5 to addr 3, then read addr 3 with resp_rdy=1 -> read response resp_data=0xA5 one cycle after read acceptance (with ACK_EN: write resp_type=1 first).
REQ-030 resp_rdy=0, issue 3 reads of addr 0,1,2 -> first two accepted, req_rdy=0 on third; raising resp_rdy drains data in order 0,1,2.
REQ-031 Occupancy 2, resp_rdy=1 and req_val=1 same cycle -> req_rdy=1, occupancy stays 2, order preserved.
REQ-032 Queue holding 2 responses, pulse reset low mid-cycle -> resp_val=0 immediately; subsequent read of prior-written addr returns old data.
REQ-033 Back-to-back reads addr 15 then 0 with resp_rdy=1 -> one response per cycle, pointer wrap, no drops or duplicates.
REQ-034 Without ACK_EN, 4 consecutive writes with resp_rdy=0 -> all accepted, resp_val stays 0.
